// File: rtl/acc_seq_pkg.sv
// rtl/acc_seq_pkg.sv - opcodes, halt address and FSM state type for acc_sequencer
package acc_seq_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ASHL  = 3'b001;
  localparam logic [2:0] OP_XNOR  = 3'b010;
  localparam logic [2:0] OP_DIV2  = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_NEG   = 3'b110;
  localparam logic [2:0] OP_JC    = 3'b111;

  // Opcode 111 with this address field means HALT instead of JC.
  localparam logic [4:0] HALT_ADDR = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - fetch/decode/execute controller driving an external combinational ALU
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_co,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              carry
);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] ir;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              is_halt;

  assign opcode  = ir[DATA_W-1 -: 3];
  assign ir_addr = ir[ADDR_W-1:0];
  assign is_halt = (opcode == OP_JC) && (ir_addr == ADDR_W'(HALT_ADDR));
  assign alu_op1 = acc;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all memory/ALU control decoded from the current state.
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    alu_op2   = '0;
    alu_sel   = OP_ADD;
    busy      = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy     = 1'b1;
        mem_addr = pc;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        // Instruction arrives now; present its operand address straight away.
        busy     = 1'b1;
        mem_addr = mem_rdata[ADDR_W-1:0];
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        busy      = 1'b1;
        mem_addr  = ir_addr;
        alu_op2   = mem_rdata;
        alu_sel   = opcode;
        mem_wdata = alu_out;
        mem_we    = (opcode == OP_STORE);
        state_d   = is_halt ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (start) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Architectural registers: ir and pc advance in DECODE, results commit at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= '0;
      pc    <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc    <= '0;
            acc   <= '0;
            carry <= 1'b0;
          end
        end
        ST_DECODE: begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        ST_EXEC: begin
          case (opcode)
            OP_ADD, OP_ASHL, OP_DIV2: begin
              acc   <= alu_out;
              carry <= alu_co;
            end
            OP_XNOR, OP_LOAD, OP_NEG: begin
              acc <= alu_out;
            end
            OP_JC: begin
              // A taken branch replaces the pc+1 made during DECODE.
              if (!is_halt && carry) pc <= ir_addr;
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Multi-cycle fetch/decode/execute controller for the 8-bit ALU in the accumulator datapath. It fetches 8-bit instructions from a unified single-port memory and reads the memory operand. It drives the combinational ALU's `op1`/`op2`/`sel` and commits the result to the accumulator, carry flag or memory. It sits between the program/data memory and the ALU at CPU top level; the ALU is instantiated beside it, not inside it.

## Interface
- `ADDR_W`, 5: memory address width; equals the instruction address field width.
- `DATA_W`, 8: data, accumulator and instruction width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: 1-cycle pulse; begins execution at address 0; honoured only in IDLE or HALTED.
- `mem_addr` out ADDR_W: memory address; combinational from state.
- `mem_rdata` in DATA_W: read data, valid the cycle after its address is presented.
- `mem_wdata` out DATA_W: write data (`alu_out`).
- `mem_we` out 1: write strobe.
- `alu_op1` out DATA_W: always the accumulator.
- `alu_op2` out DATA_W: operand (`mem_rdata` in EXEC, else 0).
- `alu_sel` out 3: ALU function select.
- `alu_out` in DATA_W: ALU result.
- `alu_co` in 1: ALU carry/shift-out.
- `busy` out 1: high in FETCH/DECODE/EXEC.
- `halted` out 1: high in HALTED.
- `acc` out DATA_W: accumulator.
- `pc` out ADDR_W: program counter.
- `carry` out 1: carry flag.

## Operation
- Instruction format: `[7:5]` opcode, `[4:0]` address `a`.
- 000 ADD: acc=acc+M[a]; carry=co.
- 001 ASHL: acc=acc<<1 (arithmetic); carry=co.
- 010 XNOR: acc=~(acc^M[a]).
- 011 DIV2: acc=acc>>>1; carry=co.
- 100 LOAD: acc=M[a] (sel 100).
- 101 STORE: M[a]=acc (sel 101); acc is unchanged.
- 110 NEG: acc=-acc (two's complement).
- 111 with a≠31 JC: if carry then pc=a. With a=31: HALT.
- `alu_sel` equals the opcode in EXEC; it is 000 in all other states.
- Carry is written only by ADD, ASHL and DIV2; it holds otherwise.
- Address arithmetic wraps modulo 2^ADDR_W (pc 31+1=0). Data arithmetic is modulo 256, with the carry out to `alu_co`.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALTED.
  - IDLE/HALTED + `start`: pc=0, acc=0, carry=0, then FETCH.
  - FETCH: `mem_addr`=pc. Next state DECODE.
  - DECODE: `mem_rdata` holds the instruction. Latch it into ir, pc=pc+1, `mem_addr`=`mem_rdata[4:0]`. Next state EXEC.
  - EXEC: `mem_rdata` holds the operand. `mem_addr`=ir[4:0]. Commit per opcode. STORE asserts `mem_we`. Next state FETCH, or HALTED on HALT.
- JC taken overrides the pc increment made in DECODE; not taken leaves pc+1.
- `start` during busy is ignored.
- Reset: state=IDLE. pc, acc, carry and ir are 0. All outputs are 0, including `mem_we`, `busy` and `halted`.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC). No stalls.
- `start` sampled high at edge t gives FETCH in cycle t+1.
- acc, carry and pc (for JC) update on the edge that ends EXEC. A STORE write occurs on that same edge.
- `halted` rises on the edge ending the HALT EXEC and stays high until `start` or reset.
- `rst_n` low mid-instruction aborts immediately and asynchronously to IDLE. No memory write occurs after reset assertion.
- The ALU is combinational. Its output is valid within EXEC and needs no pipeline register.

## Structure
- Shared package `acc_seq_pkg`: opcode localparams (OP_ADD…OP_JC), `HALT_ADDR`=5'h1F, and the state enum `state_t`.
- Single module with no sub-module. FSM, ir/pc/acc/carry registers and output decode live in one file.
- The ALU is instantiated at top level with `alu_op1`/`alu_op2`/`alu_sel` wired to its `op1`/`op2`/`sel`.
- The bench pairs this block with the real ALU plus a behavioural 32×8 memory with 1-cycle read latency.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXEC of a STORE. Required: all outputs 0 and `mem_we`=0 immediately; the memory word is unchanged.
- **LOAD/ADD carry:** M0=0x8A, M1=0x0B, M2=0xFF, M10=0x05, M11=0xFE, then pulse `start`. Required: acc=0x03, carry=1, `halted` at cycle 9 after `start`.
- **STORE/NEG:** program LOAD 10 (M10=0x05), NEG, STORE 12, HALT. Required: M12=0xFB, acc=0xFB, `mem_we` high in exactly one cycle.
- **Branch:** carry=1 from ASHL of 0x80, then JC 6, with M6=HALT. Required: pc=6 after the JC EXEC and the instruction at pc 5 is never fetched. Repeat with carry=0: execution falls through.
- **Carry hold:** ADD sets carry=1, then XNOR and LOAD execute. Required: carry stays 1. A following DIV2 of 0x04 clears carry and gives acc=0x02.
- **Control:** `start` pulsed while busy has no effect. pc wraps 31→0 on a program filling memory. `start` from HALTED restarts at pc=0 with acc=0.
